// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter driving the SRAM latch-edge/access-edge sequence.
// Define SRAM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority to port 0.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH/8-1:0] p0_be,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  output logic                    p0_gnt,
  output logic                    p0_done,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  output logic                    p1_gnt,
  output logic                    p1_done,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   sram_addr_sel,
  output logic [DATA_WIDTH/8-1:0] sram_byte_sel,
  output logic                    sram_read_enable,
  output logic                    sram_write_enable,
  output logic [DATA_WIDTH-1:0]   sram_datain,
  input  logic [DATA_WIDTH-1:0]   sram_dataout
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;
  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BE_WIDTH-1:0]     be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q, owner_q, pick1, grant, active, last_cycle;
`ifdef SRAM_ARB_RR_EN
  // last_q remembers the most recently served port; reset to 1 so port 0 wins first
  logic last_q;
  always_comb pick1 = p1_req & (~p0_req | ~last_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else if (grant) last_q <= pick1;
`else
  always_comb pick1 = p1_req & ~p0_req;
`endif
  always_comb begin
    grant             = state == IDLE && (p0_req || p1_req);
    p0_gnt            = grant & ~pick1;
    p1_gnt            = grant & pick1;
    active            = state != IDLE;
    last_cycle        = state == CAPTURE || (state == ACCESS && we_q);
    state_nx          = state == IDLE   ? (grant ? SETUP : IDLE) :
                        state == SETUP  ? ACCESS :
                        state == ACCESS ? (we_q ? IDLE : CAPTURE) : IDLE;
    busy              = active;
    sram_addr_sel     = active ? addr_q : '0;
    sram_byte_sel     = active ? (we_q ? be_q : '1) : '0;
    sram_read_enable  = active & ~we_q;
    sram_write_enable = active & we_q;
    sram_datain       = active ? wdata_q : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        we_q    <= pick1 ? p1_we : p0_we;
        addr_q  <= pick1 ? p1_addr : p0_addr;
        be_q    <= pick1 ? p1_be : p0_be;
        wdata_q <= pick1 ? p1_wdata : p0_wdata;
        owner_q <= pick1;
      end
      p0_done <= last_cycle & ~owner_q;
      p1_done <= last_cycle & owner_q;
      if (state == CAPTURE && !owner_q) p0_rdata <= sram_dataout;
      if (state == CAPTURE && owner_q) p1_rdata <= sram_dataout;
    end
endmodule
